// File: rtl/instr_fetch_if.sv
// Bundles the program-load handshake, ROM write/address bus and the decode controls of instr_fetch.
// The master modport is the fetch unit; the slave modport is the loader/decode/ROM side.
interface instr_fetch_if #(
  parameter int A = 6,
  parameter int W = 8
);
  logic         Start;
  logic         LoadValid;
  logic [W-1:0] LoadData;
  logic         LoadLast;
  logic         LoadReady;
  logic         Stall;
  logic         BranchEn;
  logic [A-1:0] BranchTarget;
  logic         Halt;
  logic [A-1:0] InstAddress;
  logic         write_enable;
  logic [W-1:0] InputData;
  logic [A:0]   LoadCount;
  logic         Running;
  logic         Done;

  modport master (
    input  Start, LoadValid, LoadData, LoadLast, Stall, BranchEn, BranchTarget, Halt,
    output LoadReady, InstAddress, write_enable, InputData, LoadCount, Running, Done
  );

  modport slave (
    output Start, LoadValid, LoadData, LoadLast, Stall, BranchEn, BranchTarget, Halt,
    input  LoadReady, InstAddress, write_enable, InputData, LoadCount, Running, Done
  );
endinterface

// File: rtl/instr_fetch.sv
// Program loader and program counter for the instruction ROM: IDLE -> LOAD -> RUN -> DONE.
// Define FETCH_REL_BRANCH_EN to treat BranchTarget as a signed PC-relative offset.
module instr_fetch #(
  parameter int A = 6,
  parameter int W = 8
) (
  input  logic          Clk,
  input  logic          Reset_n,
  instr_fetch_if.master bus
);
  typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

  localparam logic [A-1:0] PC_MAX = {A{1'b1}};

  state_t       state_q, state_d;
  logic [A-1:0] pc_q, pc_d;
  logic [A:0]   count_q, count_d;
  logic         running_q, running_d;
  logic         done_q, done_d;
  logic         transfer;
  logic [A-1:0] branch_pc;

  assign transfer = (state_q == LOAD) && bus.LoadValid;

`ifdef FETCH_REL_BRANCH_EN
  // Two's-complement add wraps modulo 2**A, so a signed offset needs no extension.
  assign branch_pc = pc_q + bus.BranchTarget;
`else
  assign branch_pc = bus.BranchTarget;
`endif

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    count_d = count_q;
    case (state_q)
      IDLE, DONE: begin
        if (bus.Start) begin
          state_d = LOAD;
          pc_d    = '0;
          count_d = '0;
        end
      end
      LOAD: begin
        if (transfer) begin
          pc_d    = pc_q + 1'b1;
          count_d = count_q + 1'b1;
          if (bus.LoadLast || (pc_q == PC_MAX)) begin
            state_d = RUN;
            pc_d    = '0;
          end
        end
      end
      RUN: begin
        // Halt outranks branch, branch outranks stall.
        if (bus.Halt) begin
          state_d = DONE;
        end else if (bus.BranchEn) begin
          pc_d = branch_pc;
        end else if (!bus.Stall) begin
          pc_d = pc_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    running_d = (state_d == RUN);
    done_d    = (state_d == DONE);
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q   <= IDLE;
      pc_q      <= '0;
      count_q   <= '0;
      running_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      count_q   <= count_d;
      running_q <= running_d;
      done_q    <= done_d;
    end
  end

  assign bus.LoadReady    = (state_q == LOAD);
  assign bus.write_enable = transfer;
  assign bus.InputData    = (state_q == LOAD) ? bus.LoadData : '0;
  assign bus.InstAddress  = pc_q;
  assign bus.LoadCount    = count_q;
  assign bus.Running      = running_q;
  assign bus.Done         = done_q;
endmodule

// File: tb/tb_instr_fetch.sv
// Randomised scoreboard bench for instr_fetch: expected ROM writes and fetch addresses are
// queued by the stimulus and popped by a negedge monitor.
module tb_instr_fetch;
  localparam int A = 6;
  localparam int W = 8;
  localparam int DEPTH = 64;

  logic Clk = 1'b0;
  logic Reset_n = 1'b0;

  instr_fetch_if #(.A(A), .W(W)) bus ();

  instr_fetch #(.A(A), .W(W)) dut (
    .Clk     (Clk),
    .Reset_n (Reset_n),
    .bus     (bus)
  );

  always #5 Clk = ~Clk;

  int testsRun = 0;
  int testsFailed = 0;
  logic [13:0] wrQ[$];
  int runQ[$];
  int expPc;
  logic [7:0] progWords[DEPTH];
  logic [13:0] wrItem;
  int runItem;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    testsRun++;
    if (act !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  // Reference PC update for a taken branch, from the architectural definition.
  function automatic int branchDest(input int pc, input int tgt);
`ifdef FETCH_REL_BRANCH_EN
    int off;
    off = (tgt >= DEPTH / 2) ? tgt - DEPTH : tgt;
    return ((pc + off) % DEPTH + DEPTH) % DEPTH;
`else
    return tgt;
`endif
  endfunction

  // BranchTarget encoding that lands on a chosen address.
  function automatic int targetFor(input int pc, input int dest);
`ifdef FETCH_REL_BRANCH_EN
    return (dest - pc + DEPTH) % DEPTH;
`else
    return dest;
`endif
  endfunction

  // Monitor: every ROM write and every RUN cycle must match the next queued expectation.
  always @(negedge Clk) begin
    if (Reset_n) begin
      if (bus.write_enable === 1'b1) begin
        if (wrQ.size() == 0) begin
          testsRun++;
          testsFailed++;
          $display("[TB] FAIL unexpected write: addr 0x%0h data 0x%0h, required no write",
                   bus.InstAddress, bus.InputData);
        end else begin
          wrItem = wrQ.pop_front();
          checkOutput("write addr", 32'(bus.InstAddress), 32'(wrItem[13:8]));
          checkOutput("write data", 32'(bus.InputData), 32'(wrItem[7:0]));
        end
      end
      if (bus.Running === 1'b1) begin
        if (runQ.size() == 0) begin
          testsRun++;
          testsFailed++;
          $display("[TB] FAIL unexpected run cycle: addr 0x%0h, required not running",
                   bus.InstAddress);
        end else begin
          runItem = runQ.pop_front();
          checkOutput("fetch addr", 32'(bus.InstAddress), 32'(runItem));
          checkOutput("run InputData", 32'(bus.InputData), 32'd0);
        end
      end
    end
  end

  task automatic runCycle(input logic st, input logic br, input int tgt, input logic hl);
    bus.Stall = st;
    bus.BranchEn = br;
    bus.BranchTarget = A'(tgt);
    bus.Halt = hl;
    runQ.push_back(expPc);
    tick();
    if (!hl) begin
      if (br) expPc = branchDest(expPc, tgt);
      else if (!st) expPc = (expPc + 1) % DEPTH;
    end
    bus.Stall = 1'b0;
    bus.BranchEn = 1'b0;
    bus.Halt = 1'b0;
  endtask

  task automatic loadProgram(input int n, input logic useLast);
    bus.Start = 1'b1;
    tick();
    bus.Start = 1'b0;
    checkOutput("load ready", 32'(bus.LoadReady), 32'd1);
    checkOutput("load start addr", 32'(bus.InstAddress), 32'd0);
    checkOutput("load start count", 32'(bus.LoadCount), 32'd0);
    for (int i = 0; i < n; i++) begin
      for (int g = $urandom_range(0, 2); g > 0; g--) begin
        bus.LoadValid = 1'b0;
        bus.LoadData = W'($urandom_range(0, 255));
        bus.LoadLast = 1'($urandom_range(0, 1));
        bus.Start = 1'($urandom_range(0, 1));
        tick();
      end
      bus.Start = 1'b0;
      bus.LoadValid = 1'b1;
      bus.LoadData = progWords[i];
      bus.LoadLast = useLast && (i == n - 1);
      wrQ.push_back({6'(i), progWords[i]});
      checkOutput("load count progress", 32'(bus.LoadCount), 32'(i));
      tick();
    end
    bus.LoadValid = 1'b0;
    bus.LoadLast = 1'b0;
    expPc = 0;
    checkOutput("LoadCount after load", 32'(bus.LoadCount), 32'(n));
    checkOutput("Running after load", 32'(bus.Running), 32'd1);
    checkOutput("addr after load", 32'(bus.InstAddress), 32'd0);
    checkOutput("LoadReady in run", 32'(bus.LoadReady), 32'd0);
  endtask

  task automatic haltAt(input int dest);
    if (expPc != dest) runCycle(1'b0, 1'b1, targetFor(expPc, dest), 1'b0);
    runCycle(1'b0, 1'b1, int'($urandom_range(0, 63)), 1'b1);
    checkOutput("Done after halt", 32'(bus.Done), 32'd1);
    checkOutput("Running after halt", 32'(bus.Running), 32'd0);
    checkOutput("halt addr", 32'(bus.InstAddress), 32'(dest));
  endtask

  task automatic applyStimulus();
    bus.Start = 1'b0;
    bus.LoadValid = 1'b0;
    bus.LoadData = '0;
    bus.LoadLast = 1'b0;
    bus.Stall = 1'b0;
    bus.BranchEn = 1'b0;
    bus.BranchTarget = '0;
    bus.Halt = 1'b0;
    repeat (2) @(posedge Clk);
    #1;
    checkOutput("reset addr", 32'(bus.InstAddress), 32'd0);
    checkOutput("reset write_enable", 32'(bus.write_enable), 32'd0);
    checkOutput("reset LoadCount", 32'(bus.LoadCount), 32'd0);
    checkOutput("reset Running", 32'(bus.Running), 32'd0);
    checkOutput("reset Done", 32'(bus.Done), 32'd0);
    checkOutput("reset LoadReady", 32'(bus.LoadReady), 32'd0);
    Reset_n = 1'b1;
    tick();
    checkOutput("idle LoadReady", 32'(bus.LoadReady), 32'd0);

    progWords[0] = 8'h11;
    progWords[1] = 8'h22;
    progWords[2] = 8'h33;
    loadProgram(3, 1'b1);

    for (int i = 0; i < 5; i++) runCycle(1'b0, 1'b0, 0, 1'b0);
    repeat (2) runCycle(1'b1, 1'b0, 0, 1'b0);
    for (int i = 0; i < 70; i++) runCycle(1'b0, 1'b0, 0, 1'b0);
    for (int i = 0; i < DEPTH && expPc != 10; i++) runCycle(1'b0, 1'b0, 0, 1'b0);
`ifdef FETCH_REL_BRANCH_EN
    runCycle(1'b1, 1'b1, 'h3E, 1'b0);
`else
    runCycle(1'b1, 1'b1, 3, 1'b0);
`endif

    for (int i = 0; i < 60; i++) begin
      bus.Start = 1'($urandom_range(0, 1));
      bus.LoadValid = 1'($urandom_range(0, 1));
      runCycle(1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0),
               int'($urandom_range(0, 63)), 1'b0);
    end
    bus.Start = 1'b0;
    bus.LoadValid = 1'b0;
    haltAt(7);

    bus.BranchEn = 1'b1;
    bus.BranchTarget = 6'd20;
    repeat (2) tick();
    bus.BranchEn = 1'b0;
    checkOutput("done hold addr", 32'(bus.InstAddress), 32'd7);
    checkOutput("done hold flag", 32'(bus.Done), 32'd1);

    for (int i = 0; i < DEPTH; i++) progWords[i] = W'($urandom_range(0, 255));
    loadProgram(DEPTH, 1'b0);
    bus.LoadValid = 1'b1;
    bus.LoadData = 8'hAA;
    #1;
    checkOutput("65th word LoadReady", 32'(bus.LoadReady), 32'd0);
    checkOutput("65th word write_enable", 32'(bus.write_enable), 32'd0);
    runCycle(1'b0, 1'b0, 0, 1'b0);
    bus.LoadValid = 1'b0;
    for (int i = 0; i < 20; i++)
      runCycle(1'($urandom_range(0, 1)), ($urandom_range(0, 2) == 0),
               int'($urandom_range(0, 63)), 1'b0);
    haltAt(int'($urandom_range(0, 63)));

    bus.Start = 1'b1;
    tick();
    bus.Start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      bus.LoadValid = 1'b1;
      bus.LoadData = W'(8'h40 + i);
      wrQ.push_back({6'(i), 8'(8'h40 + i)});
      tick();
    end
    bus.LoadData = 8'h5A;
    #1;
    checkOutput("pre-reset write_enable", 32'(bus.write_enable), 32'd1);
    Reset_n = 1'b0;
    #1;
    checkOutput("mid-load reset write_enable", 32'(bus.write_enable), 32'd0);
    checkOutput("mid-load reset addr", 32'(bus.InstAddress), 32'd0);
    checkOutput("mid-load reset LoadCount", 32'(bus.LoadCount), 32'd0);
    checkOutput("mid-load reset LoadReady", 32'(bus.LoadReady), 32'd0);
    bus.LoadValid = 1'b0;
    tick();
    Reset_n = 1'b1;
    tick();
    checkOutput("post-reset idle", 32'(bus.LoadReady), 32'd0);

    progWords[0] = 8'hC3;
    progWords[1] = 8'h3C;
    loadProgram(2, 1'b1);
    runCycle(1'b0, 1'b0, 0, 1'b0);
    runCycle(1'b0, 1'b0, 0, 1'b1);
    checkOutput("final Done", 32'(bus.Done), 32'd1);
    tick();
    checkOutput("writes drained", 32'(wrQ.size()), 32'd0);
    checkOutput("fetches drained", 32'(runQ.size()), 32'd0);
  endtask

  initial begin
    applyStimulus();
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation still running, required completion");
    $fatal(1, "[TB] watchdog expired");
  end
endmodule
